// File: rtl/filter_pkg.sv
// Shared definitions for the edge-filter frame sequencer.
// Holds the default frame geometry, coordinate widths, the filter mode and
// sequencer state enums, and helpers that map a requested mode to a legal mode
// and to its kernel radius.
package filter_pkg;

  localparam int unsigned IMG_W_DEFAULT = 320;
  localparam int unsigned IMG_H_DEFAULT = 240;
  localparam int unsigned COL_W         = 9;
  localparam int unsigned ROW_W         = 8;
  localparam int unsigned MODE_W        = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS = 3'd0,
    MODE_3X3  = 3'd1,
    MODE_5X5  = 3'd2
  } mode_e;

  typedef enum logic [1:0] {
    StWaitSop = 2'd0,
    StInFrame = 2'd1,
    StResync  = 2'd2
  } seq_state_e;

  // Undefined request codes fall back to pass-through.
  function automatic mode_e sanitize_mode(input logic [MODE_W-1:0] req);
    mode_e m;
    case (req)
      3'd1:    m = MODE_3X3;
      3'd2:    m = MODE_5X5;
      default: m = MODE_PASS;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] mode_radius(input mode_e mode);
    logic [1:0] r;
    case (mode)
      MODE_3X3: r = 2'd1;
      MODE_5X5: r = 2'd2;
      default:  r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/filter_sequencer_if.sv
// Stream-side signal bundle of the filter sequencer.
// master: the stream source / monitor side (drives mode_req and beat qualifiers).
// slave:  the sequencer (drives freq_flag, col/row, border, status and count).
interface filter_sequencer_if
  import filter_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic [MODE_W-1:0] mode_req;
  logic              valid_in;
  logic              ready_in;
  logic              startofpacket_in;
  logic              endofpacket_in;
  logic [MODE_W-1:0] freq_flag;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              border;
  logic              in_frame;
  logic              frame_done;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_count;

  modport master (
    output mode_req, valid_in, ready_in, startofpacket_in, endofpacket_in,
    input  freq_flag, col, row, border, in_frame, frame_done, frame_err, frame_count
  );

  modport slave (
    input  mode_req, valid_in, ready_in, startofpacket_in, endofpacket_in,
    output freq_flag, col, row, border, in_frame, frame_done, frame_err, frame_count
  );
endinterface

// File: rtl/pixel_position_counter.sv
// Column/row position of the next beat within an IMG_W x IMG_H frame.
// Ports: clk, reset (sync, active-high); advance steps one pixel in raster order;
// clear returns to (0,0); clear together with advance lands on the pixel after
// (0,0), used when an SOP beat is counted. col/row are registered; last_pixel
// flags (IMG_W-1, IMG_H-1).
module pixel_position_counter
  import filter_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEFAULT,
  parameter int unsigned IMG_H = IMG_H_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             clear,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_pixel
);

  localparam logic [COL_W-1:0] ColLast = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_end, row_end;

  assign col_end = (col_q == ColLast);
  assign row_end = (row_q == RowLast);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
      if (advance) begin
        col_d = COL_W'(1);
      end
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col        = col_q;
  assign row        = row_q;
  assign last_pixel = col_end && row_end;

endmodule

// File: rtl/filter_sequencer.sv
// Frame-level controller for the edge filter.
// Ports: clk, reset (sync, active-high), bus (slave side of filter_sequencer_if).
// Tracks the raster position of accepted beats, latches the filter mode only
// between frames, decodes kernel-border pixels combinationally for the current
// beat, and reports completed (frame_done, frame_count) and malformed
// (frame_err) frames with one-cycle pulses.
module filter_sequencer
  import filter_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEFAULT,
  parameter int unsigned IMG_H = IMG_H_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                reset,
  filter_sequencer_if.slave  bus
);

  localparam logic [COL_W-1:0] ColLast = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(IMG_H - 1);

  seq_state_e       state_q, state_d;
  mode_e            freq_q, freq_d;
  mode_e            mode_san;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept, sop_acc;
  logic             cnt_advance, cnt_clear;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_pixel;

  assign accept   = bus.valid_in && bus.ready_in;
  assign sop_acc  = accept && bus.startofpacket_in;
  assign mode_san = sanitize_mode(bus.mode_req);

  pixel_position_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_pos (
    .clk        (clk),
    .reset      (reset),
    .advance    (cnt_advance),
    .clear      (cnt_clear),
    .col        (col),
    .row        (row),
    .last_pixel (last_pixel)
  );

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    count_d     = count_q;
    cnt_advance = 1'b0;
    cnt_clear   = 1'b0;

    unique case (state_q)
      StWaitSop, StResync: begin
        freq_d = mode_san;
        if (sop_acc) begin
          cnt_clear = 1'b1;
          if (bus.endofpacket_in) begin
            err_d   = 1'b1;
            state_d = StWaitSop;
          end else begin
            cnt_advance = 1'b1;
            state_d     = StInFrame;
          end
        end
      end

      StInFrame: begin
        if (accept) begin
          if (bus.startofpacket_in) begin
            // Stray SOP restarts at (0,0) under the newly requested mode; an EOP on the
            // same beat can only be a short frame since (0,0) is never the last pixel.
            err_d     = 1'b1;
            freq_d    = mode_san;
            cnt_clear = 1'b1;
            if (bus.endofpacket_in) begin
              state_d = StWaitSop;
            end else begin
              cnt_advance = 1'b1;
            end
          end else if (bus.endofpacket_in) begin
            freq_d    = mode_san;
            cnt_clear = 1'b1;
            state_d   = StWaitSop;
            if (last_pixel) begin
              done_d  = 1'b1;
              count_d = count_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (last_pixel) begin
            err_d     = 1'b1;
            freq_d    = mode_san;
            cnt_clear = 1'b1;
            state_d   = StResync;
          end else begin
            cnt_advance = 1'b1;
          end
        end
      end

      default: begin
        state_d = StWaitSop;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWaitSop;
      freq_q  <= MODE_PASS;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Border decode of the beat currently on the bus; an SOP beat is (0,0) by definition.
  logic [COL_W-1:0] cur_c;
  logic [ROW_W-1:0] cur_r;
  logic [1:0]       radius;
  logic             edge_hit;

  always_comb begin
    cur_c    = sop_acc ? '0 : col;
    cur_r    = sop_acc ? '0 : row;
    radius   = mode_radius(freq_q);
    // c >= W-R written as c > (W-1)-R so the constant never needs an extra bit.
    edge_hit = (cur_c < COL_W'(radius)) || (cur_c > ColLast - COL_W'(radius)) ||
               (cur_r < ROW_W'(radius)) || (cur_r > RowLast - ROW_W'(radius));
  end

  assign bus.border      = ((state_q == StInFrame) || sop_acc) && (radius != 2'd0) && edge_hit;
  assign bus.freq_flag   = freq_q;
  assign bus.col         = col;
  assign bus.row         = row;
  assign bus.in_frame    = (state_q == StInFrame);
  assign bus.frame_done  = done_q;
  assign bus.frame_err   = err_q;
  assign bus.frame_count = count_q;

endmodule

// File: tb/tb_filter_sequencer.sv
// Self-checking bench for filter_sequencer. Runs a reduced 20x10 frame so
// full-frame sequences stay short; a pixel-index reference model checks every
// cycle, alongside a vector table, directed sequences and random traffic.
module tb_filter_sequencer;
  import filter_pkg::*;

  localparam int W     = 20;
  localparam int H     = 10;
  localparam int NPIX  = W * H;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  filter_sequencer_if #(.CNT_W(CNT_W)) bus ();

  filter_sequencer #(
    .IMG_W (W),
    .IMG_H (H),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: frame position as a linear pixel index.
  bit          m_in;
  int          m_p;
  logic [2:0]  m_mode;
  bit          m_done, m_err;
  logic [15:0] m_count;

  logic g_border;
  logic brd [NPIX];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [63:0] dut_vec();
    return {24'd0, bus.frame_count, bus.freq_flag, bus.col, bus.row, bus.border,
            bus.in_frame, bus.frame_done, bus.frame_err};
  endfunction

  function automatic logic [63:0] model_vec(input bit sop_acc);
    int   c, r, rad;
    logic b;
    c   = sop_acc ? 0 : m_p % W;
    r   = sop_acc ? 0 : m_p / W;
    rad = int'(m_mode);
    b   = (m_in || sop_acc) && (rad > 0) &&
          (c < rad || c >= W - rad || r < rad || r >= H - rad);
    return {24'd0, m_count, m_mode, 9'(m_p % W), 8'(m_p / W), b, m_in, m_done, m_err};
  endfunction

  function automatic void model_reset();
    m_in = 0; m_p = 0; m_mode = 3'd0; m_done = 0; m_err = 0; m_count = 16'd0;
  endfunction

  function automatic void model_update(input bit acc, input bit s, input bit e,
                                       input logic [2:0] m);
    logic [2:0] san;
    int         cur;
    san    = (m <= 3'd2) ? m : 3'd0;
    m_done = 0;
    m_err  = 0;
    if (!m_in) begin
      m_mode = san;
      if (acc && s) begin
        if (e) m_err = 1;
        else begin
          m_in = 1;
          m_p  = 1;
        end
      end
    end else if (acc) begin
      cur = m_p;
      if (s) begin
        m_err  = 1;
        m_mode = san;
        cur    = 0;
      end
      if (e) begin
        if (cur == NPIX - 1) begin
          m_done  = 1;
          m_count = m_count + 16'd1;
        end else m_err = 1;
        m_in   = 0;
        m_p    = 0;
        m_mode = san;
      end else if (cur == NPIX - 1) begin
        m_err  = 1;
        m_in   = 0;
        m_p    = 0;
        m_mode = san;
      end else m_p = cur + 1;
    end
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic v, input logic rdy, input logic s, input logic e,
                      input logic [2:0] m);
    @(negedge clk);
    bus.valid_in         = v;
    bus.ready_in         = rdy;
    bus.startofpacket_in = s;
    bus.endofpacket_in   = e;
    bus.mode_req         = m;
    #1;
    check("cycle", dut_vec(), model_vec(v && rdy && s));
    g_border = bus.border;
    @(posedge clk);
    model_update(v && rdy, s, e, m);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset                = 1'b1;
    bus.valid_in         = 1'b0;
    bus.ready_in         = 1'b0;
    bus.startofpacket_in = 1'b0;
    bus.endofpacket_in   = 1'b0;
    bus.mode_req         = 3'd0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    check("rst_vals", {bus.frame_count, bus.freq_flag, bus.col, bus.row, bus.in_frame,
                       bus.frame_done, bus.frame_err}, 64'd0);
  endtask

  task automatic frame_beats(input int from, input int to, input logic [2:0] m1,
                             input logic [2:0] m2, input int chg, input bit sop_first,
                             input bit eop_last);
    for (int p = from; p <= to; p++) begin
      step(1'b1, 1'b1, sop_first && p == from, eop_last && p == to, (p >= chg) ? m2 : m1);
      brd[p] = g_border;
    end
  endtask

  function automatic logic [W-1:0] row_bits(input int r);
    logic [W-1:0] rb;
    for (int c = 0; c < W; c++) rb[c] = brd[r * W + c];
    return rb;
  endfunction

  typedef struct {
    logic       v, r, s, e;
    logic [2:0] m;
    logic       exp_border;
    logic [8:0] exp_col;
    logic [7:0] exp_row;
    logic [2:0] exp_freq;
    logic       exp_in, exp_err;
  } vec_t;

  function automatic vec_t mk(input logic v, r, s, e, input logic [2:0] m, input logic b,
                              input int c, input int rw, input logic [2:0] f,
                              input logic in_f, input logic er);
    vec_t t;
    t.v = v; t.r = r; t.s = s; t.e = e; t.m = m; t.exp_border = b;
    t.exp_col = 9'(c); t.exp_row = 8'(rw); t.exp_freq = f; t.exp_in = in_f; t.exp_err = er;
    return t;
  endfunction

  vec_t tbl [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] exp2;
    logic         any_b;
    logic [16:0]  q1 [$];
    logic [16:0]  q2 [$];
    int           k, guard, mism;
    logic         rdy, v, s, e;
    logic [2:0]   cur_mode;

    reset = 1'b1;
    do_reset();

    // Single-cycle vectors from reset: {v,r,s,e,mode} -> border now, state after edge.
    tbl[0]  = mk(1, 1, 0, 0, 3'd1, 0, 0, 0, 3'd1, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 3'd2, 0, 0, 0, 3'd2, 0, 0);
    tbl[2]  = mk(1, 0, 1, 0, 3'd2, 0, 0, 0, 3'd2, 0, 0);
    tbl[3]  = mk(1, 1, 1, 0, 3'd2, 1, 1, 0, 3'd2, 1, 0);
    tbl[4]  = mk(1, 1, 0, 0, 3'd0, 1, 2, 0, 3'd2, 1, 0);
    tbl[5]  = mk(0, 0, 0, 1, 3'd0, 1, 2, 0, 3'd2, 1, 0);
    tbl[6]  = mk(1, 1, 1, 1, 3'd1, 1, 0, 0, 3'd1, 0, 1);
    tbl[7]  = mk(1, 1, 1, 1, 3'd0, 1, 0, 0, 3'd0, 0, 1);
    tbl[8]  = mk(1, 1, 0, 0, 3'd0, 0, 0, 0, 3'd0, 0, 0);
    tbl[9]  = mk(1, 1, 1, 0, 3'd0, 0, 1, 0, 3'd0, 1, 0);
    tbl[10] = mk(1, 1, 0, 0, 3'd2, 0, 2, 0, 3'd0, 1, 0);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].m);
      check("tbl_border", g_border, tbl[i].exp_border);
      check("tbl_state", {bus.col, bus.row, bus.freq_flag, bus.in_frame, bus.frame_err},
            {tbl[i].exp_col, tbl[i].exp_row, tbl[i].exp_freq, tbl[i].exp_in, tbl[i].exp_err});
    end

    // Mode change mid-frame: request 1 -> 2 at pixel (10,5).
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    frame_beats(0, NPIX - 2, 3'd1, 3'd2, 5 * W + 10, 1, 0);
    check("modechg_hold", bus.freq_flag, 3'd1);
    frame_beats(NPIX - 1, NPIX - 1, 3'd2, 3'd2, 0, 0, 1);
    check("modechg_freq", bus.freq_flag, 3'd2);
    check("modechg_done", bus.frame_done, 1'b1);
    check("modechg_count", bus.frame_count, 16'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    check("modechg_pulse", bus.frame_done, 1'b0);

    // Border map in mode 2, then mode 0.
    frame_beats(0, NPIX - 1, 3'd2, 3'd2, 0, 1, 1);
    exp2 = '0;
    exp2[0] = 1'b1; exp2[1] = 1'b1; exp2[W-2] = 1'b1; exp2[W-1] = 1'b1;
    check("brd_row0", row_bits(0), {W{1'b1}});
    check("brd_row2", row_bits(2), exp2);
    check("brd_rowh2", row_bits(H - 2), {W{1'b1}});
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    frame_beats(0, NPIX - 1, 3'd0, 3'd0, 0, 1, 1);
    any_b = 1'b0;
    for (int p = 0; p < NPIX; p++) any_b = any_b | brd[p];
    check("brd_mode0", any_b, 1'b0);
    check("brd_count", bus.frame_count, 16'd3);

    // Short frame: EOP at (W-1,4).
    frame_beats(0, 4 * W + W - 1, 3'd0, 3'd0, 0, 1, 1);
    check("short_err", bus.frame_err, 1'b1);
    check("short_done", bus.frame_done, 1'b0);
    check("short_count", bus.frame_count, 16'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("short_pulse", bus.frame_err, 1'b0);
    frame_beats(0, NPIX - 1, 3'd0, 3'd0, 0, 1, 1);
    check("short_next", {bus.frame_done, bus.frame_count}, {1'b1, 16'd4});

    // Long frame: last pixel without EOP, then 10 stray beats.
    frame_beats(0, NPIX - 1, 3'd0, 3'd0, 0, 1, 0);
    check("long_err", {bus.frame_err, bus.in_frame}, 2'b10);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      check("long_ignore", {bus.col, bus.row, bus.in_frame}, 18'd0);
    end
    frame_beats(0, NPIX - 1, 3'd0, 3'd0, 0, 1, 1);
    check("long_count", {bus.frame_done, bus.frame_count}, {1'b1, 16'd5});

    // Reset with the counters at (10,5).
    frame_beats(0, 5 * W + 9, 3'd0, 3'd0, 0, 1, 0);
    check("rst_pos", {bus.col, bus.row}, {9'd10, 8'd5});
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    check("rst_nosop", {bus.col, bus.in_frame}, 10'd0);

    // Stalls must not change the accepted-beat position sequence.
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b1, i == 0, 1'b0, 3'd0);
      q1.push_back({bus.col, bus.row});
    end
    do_reset();
    k = 0;
    guard = 0;
    while (k < 60 && guard < 2000) begin
      rdy = 1'(($urandom % 2));
      step(1'b1, rdy, k == 0, 1'b0, 3'd0);
      if (rdy) begin
        q2.push_back({bus.col, bus.row});
        k++;
      end
      guard++;
    end
    check("stall_len", q2.size(), 60);
    mism = 0;
    for (int i = 0; i < 60 && i < q2.size(); i++) if (q1[i] !== q2[i]) mism++;
    check("stall_seq", mism, 0);
    frame_beats(60, 64, 3'd0, 3'd0, 0, 0, 0);
    check("stray_pos", {bus.col, bus.row}, {9'd5, 8'd3});
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    check("stray_sop", {bus.frame_err, bus.in_frame, bus.col, bus.row},
          {1'b1, 1'b1, 9'd1, 8'd0});

    // Random traffic against the model.
    do_reset();
    cur_mode = 3'd0;
    for (int i = 0; i < 6000; i++) begin
      v   = 1'(($urandom % 4) != 0);
      rdy = 1'(($urandom % 4) != 0);
      if (($urandom % 16) == 0) cur_mode = 3'($urandom % 8);
      if (!m_in) begin
        s = 1'(($urandom % 3) == 0);
        e = 1'(($urandom % 20) == 0);
      end else if (m_p == NPIX - 1) begin
        s = 1'b0;
        e = 1'(($urandom % 8) != 0);
      end else begin
        s = 1'(($urandom % 500) == 0);
        e = 1'(($urandom % 400) == 0);
      end
      step(v, rdy, s, e, cur_mode);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
